usb_sipo_deser: RTL
===================

Name: usb_sipo_deser

Overview:
Parametrised serial-to-parallel deserializer for the USB receive path. It is the successor to the fixed 8-bit shift-and-hold register and adds the following:
- configurable word width and bit order;
- a bit-strobe input;
- a valid/ready holding register with overrun detection;
- optional USB bit-unstuffing.

It sits between the NRZI decoder (serial bits) and the packet/PID logic (parallel words).

Parameters:
- WIDTH, 8: parallel word width in bits; legal range 2..32.
- LSB_FIRST, 1: 1 means the first received bit lands in parallel_out[0] (USB order); 0 means the first bit lands in parallel_out[WIDTH-1].

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- serial_in, input, 1: serial data bit.
- bit_valid, input, 1: serial_in is sampled on a clk edge only when bit_valid=1.
- select_pin, input, 1: 1 enables reception; 0 holds and clears the partial word.
- parallel_out, output, WIDTH: holding register, i.e. the last completed word.
- word_valid, output, 1: parallel_out holds an unconsumed word.
- word_ready, input, 1: consumer accepts the word when word_valid=1 and word_ready=1.
- bit_count, output, clog2(WIDTH)+1: number of bits in the current partial word.
- overrun, output, 1: one-cycle pulse when a completed word is dropped.
- stuff_err, output, 1: one-cycle pulse on a bit-stuffing violation; tied to 0 when the optional feature is out.

Behaviour:
- Reset: when rst=1 at a clk edge, all outputs, the shift register, bit_count and the ones counter become 0. Reset mid-word discards the partial word and any held word.
- Accepted bit: a clk edge with select_pin=1 and bit_valid=1 (and the bit is not dropped by unstuffing). It shifts into the shift register per LSB_FIRST, and bit_count increments.
- Word completion: the edge that accepts the WIDTH-th bit is the completion edge.
  - The complete word goes to the holding register if word_valid=0, or if word_ready=1 at that same edge.
  - In that case parallel_out and word_valid=1 become visible after that edge (latency 1 clk from last bit sample).
  - bit_count returns to 0.
- Overrun: if completion occurs while word_valid=1 and word_ready=0:
  - the new word is dropped;
  - parallel_out is unchanged;
  - overrun=1 for exactly one cycle;
  - bit_count returns to 0.
- Handshake:
  - word_valid=1 and word_ready=1 with no completion: word_valid becomes 0 next cycle.
  - Simultaneous completion and ready: word_valid stays 1 and parallel_out takes the new word.
  - parallel_out is never altered while word_valid=1 except on that simultaneous case.
- select_pin=0 (framing reset):
  - shift register, bit_count and ones counter clear;
  - bit_valid is ignored;
  - parallel_out and word_valid are unaffected, so the handshake still works.
- bit_valid=0 with select_pin=1: all state holds. Gaps of any length between bits are legal.
- word_ready while word_valid=0: no effect.

Optional Feature:
Macro USB_BIT_UNSTUFF_EN.
- When defined, a ones counter (0..6) tracks consecutive sampled 1s. The counter advances only on edges with select_pin=1 and bit_valid=1.
  - Counter=6 and bit=0: the bit is a stuffed bit. It is dropped (not shifted, bit_count unchanged) and the counter resets to 0.
  - Counter=6 and bit=1: stuff_err pulses for one cycle, the partial word and bit_count clear, and the counter resets to 0.
  - Any other 0 bit resets the counter; a 1 bit increments it.
  - The counter persists across word boundaries.
- When not defined: no ones counter exists, every sampled bit is accepted, and stuff_err is constant 0.

Decomposition:
- Shared package usb_pkg:
  - localparam USB_STUFF_LIMIT=6;
  - default word width USB_WORD_W=8;
  - a bit_count width function, clog2.
- One natural sub-module, usb_bit_unstuffer:
  - inputs: clk, rst, select_pin, bit_valid, serial_in;
  - outputs: bit_accept, stuff_err;
  - instantiated only under USB_BIT_UNSTUFF_EN. Otherwise bit_accept = select_pin & bit_valid.

Test Plan:
1. WIDTH=8, LSB_FIRST=1, word_ready=1: bits 1,0,1,1,0,0,1,0 with bit_valid each cycle. Expect parallel_out=8'h4D and word_valid=1 one cycle after the 8th bit, then word_valid=0 next cycle.
2. Same bits with LSB_FIRST=0. Expect parallel_out=8'hB2.
3. word_ready=0: send two full words 8'h4D then 8'hFF. Expect the first held, overrun pulsing one cycle on the 2nd completion, and parallel_out staying 8'h4D. Then word_ready=1 gives word_valid=0.
4. select_pin 1→0 after 5 bits, then 1 again and send 8 bits for 8'hA5. Expect bit_count=0 during deselect and parallel_out=8'hA5, with no corruption from the discarded 5 bits.
5. With USB_BIT_UNSTUFF_EN: bits 1,1,1,1,1,1,0,0,1 (9 samples). Expect the 7th bit dropped, parallel_out=8'hBF and stuff_err=0. Then seven consecutive 1s give a stuff_err one-cycle pulse and bit_count=0.
6. rst=1 asserted after 4 bits with word_valid=1. Expect all outputs 0 next cycle. A following full word completes normally.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared constants and helpers for the USB receive-path blocks.
package usb_pkg;

  localparam int USB_STUFF_LIMIT = 6;
  localparam int USB_WORD_W      = 8;

  // Ceiling log2, usable in constant expressions for port widths.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/usb_bit_unstuffer.sv
// USB bit-unstuffer: counts consecutive sampled 1s, drops the stuffed 0 after six
// of them and flags a seventh 1 as a violation on the same edge it is sampled.
module usb_bit_unstuffer
  import usb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic select_pin,
  input  logic bit_valid,
  input  logic serial_in,
  output logic bit_accept,
  output logic stuff_err
);

  logic [2:0] ones_count;
  logic       sample;
  logic       at_limit;

  // stuff_err is combinational so the deserializer can discard its partial word
  // on the very edge the violating bit is sampled.
  always_comb begin
    sample     = select_pin & bit_valid;
    at_limit   = (ones_count == 3'(USB_STUFF_LIMIT));
    bit_accept = sample & ~at_limit;
    stuff_err  = sample & at_limit & serial_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ones_count <= '0;
    end else if (!select_pin) begin
      ones_count <= '0;
    end else if (bit_valid) begin
      if (at_limit || !serial_in) begin
        ones_count <= '0;
      end else begin
        ones_count <= ones_count + 3'd1;
      end
    end
  end

endmodule

// File: rtl/usb_sipo_deser.sv
// Parametrised USB receive deserializer with a valid/ready holding register.
// Define USB_BIT_UNSTUFF_EN to include bit-unstuffing and stuff-error detection.
module usb_sipo_deser
  import usb_pkg::*;
#(
  parameter int WIDTH     = USB_WORD_W,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    serial_in,
  input  logic                    bit_valid,
  input  logic                    select_pin,
  output logic [WIDTH-1:0]        parallel_out,
  output logic                    word_valid,
  input  logic                    word_ready,
  output logic [clog2(WIDTH):0]   bit_count,
  output logic                    overrun,
  output logic                    stuff_err
);

  localparam int CW = clog2(WIDTH) + 1;

  logic             bit_accept;
  logic             stuff_hit;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shifted;
  logic             complete;
  logic             can_load;

`ifdef USB_BIT_UNSTUFF_EN
  usb_bit_unstuffer u_unstuffer (
    .clk        (clk),
    .rst        (rst),
    .select_pin (select_pin),
    .bit_valid  (bit_valid),
    .serial_in  (serial_in),
    .bit_accept (bit_accept),
    .stuff_err  (stuff_hit)
  );
`else
  assign bit_accept = select_pin & bit_valid;
  assign stuff_hit  = 1'b0;
`endif

  // shifted is the register contents including the bit on this edge, so the
  // completed word can be loaded straight into the holding register.
  always_comb begin
    shifted = shift_reg;
    if (LSB_FIRST) begin
      shifted = {serial_in, shift_reg[WIDTH-1:1]};
    end else begin
      shifted = {shift_reg[WIDTH-2:0], serial_in};
    end
    complete = bit_accept && (bit_count == CW'(WIDTH - 1));
    can_load = !word_valid || word_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg    <= '0;
      bit_count    <= '0;
      parallel_out <= '0;
      word_valid   <= 1'b0;
      overrun      <= 1'b0;
      stuff_err    <= 1'b0;
    end else begin
      overrun   <= complete && !can_load;
      stuff_err <= stuff_hit;

      if (!select_pin || stuff_hit) begin
        shift_reg <= '0;
        bit_count <= '0;
      end else if (bit_accept) begin
        if (complete) begin
          shift_reg <= '0;
          bit_count <= '0;
        end else begin
          shift_reg <= shifted;
          bit_count <= bit_count + 1'b1;
        end
      end

      // A completed word wins over a plain consume when both happen together.
      if (complete && can_load) begin
        parallel_out <= shifted;
        word_valid   <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule
